// File: rtl/fwd_pkg.sv
// fwd_pkg: shared definitions for the EX-stage operand-forwarding block.
//   FWD_SEL_*      : source codes reported on fwd_sel per channel
//   fwd_state_t    : load-use stall FSM state (FWD_RUN, FWD_WAIT)
//   fwd_hist_ent_t : logical layout of one write-history entry at the
//                    default widths. The top level keeps the same three
//                    fields as parameter-sized arrays so that DATA_W/REG_AW
//                    stay configurable.
package fwd_pkg;

  localparam int FWD_SEL_W = 3;

  localparam logic [FWD_SEL_W-1:0] FWD_SEL_RF   = 3'd0;
  localparam logic [FWD_SEL_W-1:0] FWD_SEL_EXM  = 3'd1;
  localparam logic [FWD_SEL_W-1:0] FWD_SEL_PC4  = 3'd2;
  localparam logic [FWD_SEL_W-1:0] FWD_SEL_MWB  = 3'd3;
  localparam logic [FWD_SEL_W-1:0] FWD_SEL_HIST = 3'd4;

  typedef enum logic {
    FWD_RUN  = 1'b0,
    FWD_WAIT = 1'b1
  } fwd_state_t;

  typedef struct packed {
    logic        vld;
    logic [4:0]  idx;
    logic [31:0] val;
  } fwd_hist_ent_t;

endpackage

// File: rtl/fwd_ch_sel.sv
// fwd_ch_sel: match and priority logic for one operand channel.
// Purely combinational. Priority, youngest first:
//   EX/MEM (result or PC+4 for links) -> MEM/WB -> history -> regfile.
// Register index 0 never matches and always selects the regfile value.
// Ports:
//   i_idx / i_rf_val          source register index and regfile value
//   i_ex_mem_*                EX/MEM writer (wr_en, idx, is_load, link, res, pc4)
//   i_mem_wb_*                MEM/WB writer (wr_en, idx, val)
//   i_hist_vld/idx/val        history entries, entry 0 youngest (flattened)
//   o_val / o_sel             forwarded operand and its source code
//   o_hazard                  operand depends on a load still in EX/MEM
module fwd_ch_sel
  import fwd_pkg::*;
#(
  parameter int DATA_W     = 32,
  parameter int REG_AW     = 5,
  parameter int HIST_DEPTH = 2
) (
  input  logic [REG_AW-1:0]            i_idx,
  input  logic [DATA_W-1:0]            i_rf_val,
  input  logic                         i_ex_mem_wr_en,
  input  logic [REG_AW-1:0]            i_ex_mem_wr_idx,
  input  logic                         i_ex_mem_is_load,
  input  logic                         i_ex_mem_link,
  input  logic [DATA_W-1:0]            i_ex_mem_res,
  input  logic [DATA_W-1:0]            i_ex_mem_pc4,
  input  logic                         i_mem_wb_wr_en,
  input  logic [REG_AW-1:0]            i_mem_wb_wr_idx,
  input  logic [DATA_W-1:0]            i_mem_wb_val,
  input  logic [HIST_DEPTH-1:0]        i_hist_vld,
  input  logic [HIST_DEPTH*REG_AW-1:0] i_hist_idx,
  input  logic [HIST_DEPTH*DATA_W-1:0] i_hist_val,
  output logic [DATA_W-1:0]            o_val,
  output logic [FWD_SEL_W-1:0]         o_sel,
  output logic                         o_hazard
);

  logic              w_nz;
  logic              w_exm_hit;
  logic              w_mwb_hit;
  logic              w_hist_hit;
  logic [DATA_W-1:0] w_hist_val;

  assign w_nz      = (i_idx != '0);
  assign w_exm_hit = w_nz && i_ex_mem_wr_en && (i_ex_mem_wr_idx == i_idx);
  assign w_mwb_hit = w_nz && i_mem_wb_wr_en && (i_mem_wb_wr_idx == i_idx);
  assign o_hazard  = w_exm_hit && i_ex_mem_is_load;

  // Scan oldest to youngest so the youngest matching entry wins.
  always_comb begin
    w_hist_hit = 1'b0;
    w_hist_val = '0;
    for (int i = HIST_DEPTH - 1; i >= 0; i--) begin
      if (w_nz && i_hist_vld[i] && (i_hist_idx[i*REG_AW +: REG_AW] == i_idx)) begin
        w_hist_hit = 1'b1;
        w_hist_val = i_hist_val[i*DATA_W +: DATA_W];
      end
    end
  end

  always_comb begin
    o_val = i_rf_val;
    o_sel = FWD_SEL_RF;
    if (w_exm_hit) begin
      if (i_ex_mem_link) begin
        o_val = i_ex_mem_pc4;
        o_sel = FWD_SEL_PC4;
      end else begin
        o_val = i_ex_mem_res;
        o_sel = FWD_SEL_EXM;
      end
    end else if (w_mwb_hit) begin
      o_val = i_mem_wb_val;
      o_sel = FWD_SEL_MWB;
    end else if (w_hist_hit) begin
      o_val = w_hist_val;
      o_sel = FWD_SEL_HIST;
    end
  end

endmodule

// File: rtl/fwd_bypass_unit.sv
// fwd_bypass_unit: NUM_CH-channel operand forwarding for the EX stage with
// a one-cycle load-use stall FSM and a saturating stall counter.
// Optional feature macro: FWD_WB_HIST_EN adds a HIST_DEPTH-entry shift
// buffer of recent MEM/WB writes (sel 4) for register files that do not
// write through in the same cycle. Without it, sel 4 is never produced.
// Ports:
//   clk, rst          clock (rising edge), asynchronous active-high reset
//   id_ex_idx/val     per-channel source index and regfile value (packed)
//   ex_mem_*          EX/MEM writer info, incl. load flag and link PC+4
//   mem_wb_*          MEM/WB writer info
//   fwd_val/fwd_sel   per-channel forwarded operand and source code
//   load_use_stall    one-cycle stall request for a load-use hazard
//   stall_cnt         saturating count of stall cycles
//   dbg_state         current stall FSM state
module fwd_bypass_unit
  import fwd_pkg::*;
#(
  parameter int DATA_W     = 32,
  parameter int REG_AW     = 5,
  parameter int NUM_CH     = 2,
  parameter int HIST_DEPTH = 2,
  parameter int CNT_W      = 16
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [NUM_CH*REG_AW-1:0]    id_ex_idx,
  input  logic [NUM_CH*DATA_W-1:0]    id_ex_val,
  input  logic                        ex_mem_wr_en,
  input  logic [REG_AW-1:0]           ex_mem_wr_idx,
  input  logic                        ex_mem_is_load,
  input  logic                        ex_mem_link,
  input  logic [DATA_W-1:0]           ex_mem_res,
  input  logic [DATA_W-1:0]           ex_mem_pc4,
  input  logic                        mem_wb_wr_en,
  input  logic [REG_AW-1:0]           mem_wb_wr_idx,
  input  logic [DATA_W-1:0]           mem_wb_val,
  output logic [NUM_CH*DATA_W-1:0]    fwd_val,
  output logic [NUM_CH*FWD_SEL_W-1:0] fwd_sel,
  output logic                        load_use_stall,
  output logic [CNT_W-1:0]            stall_cnt,
  output fwd_state_t                  dbg_state
);

  fwd_state_t               r_state;
  fwd_state_t               w_state_nxt;
  logic [CNT_W-1:0]         r_stall_cnt;
  logic [NUM_CH-1:0]        w_ch_hazard;
  logic                     w_hazard;
  logic [HIST_DEPTH-1:0]        w_hist_vld;
  logic [HIST_DEPTH*REG_AW-1:0] w_hist_idx;
  logic [HIST_DEPTH*DATA_W-1:0] w_hist_val;

`ifdef FWD_WB_HIST_EN
  logic [HIST_DEPTH-1:0]        r_hist_vld;
  logic [HIST_DEPTH*REG_AW-1:0] r_hist_idx;
  logic [HIST_DEPTH*DATA_W-1:0] r_hist_val;

  // Entry 0 is the youngest; a push shifts everything one slot older and
  // drops the oldest entry. Writes to register 0 are not recorded.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_hist_vld <= '0;
      r_hist_idx <= '0;
      r_hist_val <= '0;
    end else if (mem_wb_wr_en && (mem_wb_wr_idx != '0)) begin
      for (int i = HIST_DEPTH - 1; i >= 1; i--) begin
        r_hist_vld[i]                 <= r_hist_vld[i-1];
        r_hist_idx[i*REG_AW +: REG_AW] <= r_hist_idx[(i-1)*REG_AW +: REG_AW];
        r_hist_val[i*DATA_W +: DATA_W] <= r_hist_val[(i-1)*DATA_W +: DATA_W];
      end
      r_hist_vld[0]          <= 1'b1;
      r_hist_idx[0 +: REG_AW] <= mem_wb_wr_idx;
      r_hist_val[0 +: DATA_W] <= mem_wb_val;
    end
  end

  assign w_hist_vld = r_hist_vld;
  assign w_hist_idx = r_hist_idx;
  assign w_hist_val = r_hist_val;
`else
  assign w_hist_vld = '0;
  assign w_hist_idx = '0;
  assign w_hist_val = '0;
`endif

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    fwd_ch_sel #(
      .DATA_W     (DATA_W),
      .REG_AW     (REG_AW),
      .HIST_DEPTH (HIST_DEPTH)
    ) u_ch (
      .i_idx            (id_ex_idx[c*REG_AW +: REG_AW]),
      .i_rf_val         (id_ex_val[c*DATA_W +: DATA_W]),
      .i_ex_mem_wr_en   (ex_mem_wr_en),
      .i_ex_mem_wr_idx  (ex_mem_wr_idx),
      .i_ex_mem_is_load (ex_mem_is_load),
      .i_ex_mem_link    (ex_mem_link),
      .i_ex_mem_res     (ex_mem_res),
      .i_ex_mem_pc4     (ex_mem_pc4),
      .i_mem_wb_wr_en   (mem_wb_wr_en),
      .i_mem_wb_wr_idx  (mem_wb_wr_idx),
      .i_mem_wb_val     (mem_wb_val),
      .i_hist_vld       (w_hist_vld),
      .i_hist_idx       (w_hist_idx),
      .i_hist_val       (w_hist_val),
      .o_val            (fwd_val[c*DATA_W +: DATA_W]),
      .o_sel            (fwd_sel[c*FWD_SEL_W +: FWD_SEL_W]),
      .o_hazard         (w_ch_hazard[c])
    );
  end

  assign w_hazard = |w_ch_hazard;

  // Stall FSM: state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= FWD_RUN;
    else     r_state <= w_state_nxt;
  end

  // Stall FSM: next state. WAIT always returns to RUN because the load has
  // then moved to MEM/WB and forwards normally.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      FWD_RUN:  if (w_hazard) w_state_nxt = FWD_WAIT;
      FWD_WAIT: w_state_nxt = FWD_RUN;
      default:  w_state_nxt = FWD_RUN;
    endcase
  end

  // Stall FSM: outputs. Stall is suppressed while reset is held.
  always_comb begin
    load_use_stall = 1'b0;
    if (!rst && (r_state == FWD_RUN) && w_hazard) load_use_stall = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_stall_cnt <= '0;
    end else if (load_use_stall && (r_stall_cnt != {CNT_W{1'b1}})) begin
      r_stall_cnt <= r_stall_cnt + 1'b1;
    end
  end

  assign stall_cnt = r_stall_cnt;
  assign dbg_state = r_state;

endmodule
